fir_mac_ctrl: RTL and testbench

FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

---
 rtl/fir_pkg.sv | 39 +++
 rtl/fir_mac.sv | 61 ++++++
 rtl/fir_mac_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_fir_mac_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC controller: FSM states, default
// parameter values and the output saturation helper.
package fir_pkg;

    localparam int TAPS_DEF      = 8;
    localparam int DW_DEF        = 8;
    localparam int ACCW_DEF      = 20;
    localparam int OUT_SHIFT_DEF = 7;

    // Working width of the saturate helper; wide enough for any sane ACCW.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Clamp a signed value into the range of a dw-bit signed number.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] value,
        input int unsigned             dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] res;
        hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 32'd1));
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Time-shared signed multiply-accumulate with a registered product stage.
// acc_next exposes the value the accumulator takes at the coming edge.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [ACCW-1:0] acc_next
);

    logic signed [2*DW-1:0] a_ext_s;
    logic signed [2*DW-1:0] b_ext_s;
    logic signed [2*DW-1:0] prod_s;
    logic signed [2*DW-1:0] prod_r;
    logic                   prod_vld_r;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] acc_next_s;

    assign a_ext_s = {{DW{a[DW-1]}}, a};
    assign b_ext_s = {{DW{b[DW-1]}}, b};
    assign prod_s  = a_ext_s * b_ext_s;

    // Accumulator update: the sign-extended registered product is added once.
    always_comb begin
        acc_next_s = acc_r;
        if (prod_vld_r) begin
            acc_next_s = acc_r + ACCW'(prod_r);
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign acc_next = acc_next_s;

    // Product pipeline register and accumulator state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r     <= '0;
            prod_vld_r <= 1'b0;
            acc_r      <= '0;
        end else if (clear) begin
            prod_r     <= '0;
            prod_vld_r <= 1'b0;
            acc_r      <= '0;
        end else begin
            acc_r      <= acc_next_s;
            prod_vld_r <= en;
            if (en) begin
                prod_r <= prod_s;
            end
        end
    end

endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR filter controller: one tap per cycle through a shared MAC, ready/valid
// on both sides. Define FIR_SAT_EN to saturate the output instead of wrapping.
module fir_mac_ctrl
    import fir_pkg::*;
#(
    parameter int TAPS      = TAPS_DEF,
    parameter int DW        = DW_DEF,
    parameter int ACCW      = ACCW_DEF,
    parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DW-1:0]      in_data,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [DW-1:0]      coef_data,
    output logic                      coef_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DW-1:0]      out_data,
    output logic                      busy
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] TAP_LAST = AW'(TAPS - 1);

    fir_state_e             state_r;
    fir_state_e             state_s;
    logic [AW-1:0]          tap_r;
    logic                   drain_r;
    logic signed [DW-1:0]   x_r [TAPS];
    logic signed [DW-1:0]   c_r [TAPS];
    logic                   out_valid_r;
    logic signed [DW-1:0]   out_data_r;
    logic                   coef_err_r;
    logic                   busy_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   mac_clear_s;
    logic                   mac_en_s;
    logic                   load_out_s;
    logic                   coef_wr_ok_s;
    logic                   coef_rej_s;
    logic signed [ACCW-1:0] acc_next_s;
    logic signed [DW-1:0]   out_next_s;

    assign in_ready_s = (state_r == ST_IDLE) & ~reset;
    assign accept_s   = in_valid & in_ready_s;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s      = state_r;
        mac_clear_s  = 1'b0;
        mac_en_s     = 1'b0;
        load_out_s   = 1'b0;
        coef_wr_ok_s = 1'b0;
        coef_rej_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                coef_wr_ok_s = coef_we;
                if (accept_s) begin
                    state_s     = ST_MAC;
                    mac_clear_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                coef_rej_s = coef_we;
                // The extra drain cycle folds the last registered product in.
                if (drain_r) begin
                    state_s    = ST_OUT;
                    load_out_s = 1'b1;
                end else begin
                    mac_en_s = 1'b1;
                end
            end
            ST_OUT: begin
                coef_wr_ok_s = coef_we;
                if (out_valid_r && out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output reduction of the shifted accumulator.
    always_comb begin
        out_next_s = '0;
`ifdef FIR_SAT_EN
        out_next_s = DW'(saturate(SAT_W'(acc_next_s >>> OUT_SHIFT), DW));
`else
        out_next_s = DW'(acc_next_s >>> OUT_SHIFT);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Tap index and drain flag sequencing the MAC pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_r   <= '0;
            drain_r <= 1'b0;
        end else if (accept_s) begin
            tap_r   <= '0;
            drain_r <= 1'b0;
        end else if (mac_en_s) begin
            tap_r <= tap_r + {{(AW-1){1'b0}}, 1'b1};
            if (tap_r == TAP_LAST) begin
                drain_r <= 1'b1;
            end
        end
    end

    // Sample delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_r[i] <= '0;
            end
        end else if (accept_s) begin
            for (int i = TAPS - 1; i > 0; i--) begin
                x_r[i] <= x_r[i-1];
            end
            x_r[0] <= in_data;
        end
    end

    // Coefficient bank; writes are only honoured outside the MAC pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                c_r[i] <= '0;
            end
        end else if (coef_wr_ok_s) begin
            c_r[coef_addr] <= coef_data;
        end
    end

    fir_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (mac_clear_s),
        .en       (mac_en_s),
        .a        (x_r[tap_r]),
        .b        (c_r[tap_r]),
        .acc_next (acc_next_s)
    );

    // Registered output handshake, error pulse and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            coef_err_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            coef_err_r <= coef_rej_s;
            busy_r     <= (state_s != ST_IDLE);
            if (load_out_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= out_next_s;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign coef_err  = coef_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl: a golden FIR model pushes expected
// outputs into a queue at each accept; tests pop and compare on output.
module tb_fir_mac_ctrl;

    localparam int TAPS = 8;
    localparam int DW   = 8;
    localparam int ACCW = 20;
    localparam int SH   = 7;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 coef_we = 1'b0;
    logic [2:0]           coef_addr = '0;
    logic signed [DW-1:0] coef_data = '0;
    logic                 coef_err;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] x_m [TAPS];
    logic signed [DW-1:0] c_m [TAPS];
    logic signed [DW-1:0] exp_q [$];

    fir_mac_ctrl #(.TAPS(TAPS), .DW(DW), .ACCW(ACCW), .OUT_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .coef_err(coef_err), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [DW-1:0] model_out();
        longint acc;
        logic signed [ACCW-1:0] acc_w;
        longint sh;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += longint'(x_m[i]) * longint'(c_m[i]);
        acc_w = acc[ACCW-1:0];
        sh = longint'(acc_w) >>> SH;
`ifdef FIR_SAT_EN
        if (sh > 127) sh = 127;
        else if (sh < -128) sh = -128;
`endif
        return sh[DW-1:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin x_m[i] = '0; c_m[i] = '0; end
        exp_q.delete();
    endtask

    task automatic model_accept(input logic signed [DW-1:0] d);
        for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
        x_m[0] = d;
        exp_q.push_back(model_out());
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic signed [DW-1:0] d);
        coef_we = 1'b1; coef_addr = addr[2:0]; coef_data = d;
        @(posedge clk);
        c_m[addr] = d;
        #1;
        coef_we = 1'b0;
    endtask

    task automatic set_all_coefs(input logic signed [DW-1:0] d);
        for (int i = 0; i < TAPS; i++) write_coef(i, d);
    endtask

    // Drive one sample and collect its output; no comparison is made here.
    task automatic send_sample(input logic signed [DW-1:0] d, input int stall,
                               output logic signed [DW-1:0] got, output int lat,
                               output bit ok);
        int n;
        ok = 1'b0; got = '0; lat = 0; n = 0;
        in_valid = 1'b1; in_data = d;
        if (stall > 0) out_ready = 1'b0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin in_valid = 1'b0; out_ready = 1'b1; return; end
        @(posedge clk);
        model_accept(d);
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (out_valid) begin
            got = out_data; ok = 1'b1;
            repeat (stall) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            coef_err !== 1'b0 || out_data !== 8'sd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b coef_err=%b out_data=%0d, required 0 0 0 0 0",
                     in_ready, out_valid, busy, coef_err, out_data);
        end
        model_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_single_tap();
        logic signed [DW-1:0] got, e;
        int lat; bit ok;
        write_coef(0, 8'sd64);
        checks++;
        if (coef_err !== 1'b0) begin
            errors++; $display("FAIL legal_write_err: coef_err=%b required 0", coef_err);
        end
        send_sample(8'sd100, 0, got, lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e || got !== 8'sd50) begin
            errors++; $display("FAIL single_tap: ok=%b out_data=%0d required %0d (50)", ok, got, e);
        end
        checks++;
        if (lat !== TAPS + 1) begin
            errors++; $display("FAIL single_tap_latency: %0d edges, required %0d", lat, TAPS + 1);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_handshake: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_impulse();
        logic signed [DW-1:0] got, e, d;
        int lat; bit ok;
        do_reset();
        set_all_coefs(8'sd16);
        for (int k = 0; k < 9; k++) begin
            d = (k == 0) ? 8'sd64 : 8'sd0;
            send_sample(d, 0, got, lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e || got !== ((k < 8) ? 8'sd8 : 8'sd0)) begin
                errors++; $display("FAIL impulse[%0d]: ok=%b out_data=%0d required %0d", k, ok, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        logic signed [DW-1:0] got, e, lim;
        int lat; bit ok;
`ifdef FIR_SAT_EN
        lim = 8'sd127;
`else
        lim = -8'sd16;
`endif
        do_reset();
        set_all_coefs(8'sd127);
        for (int k = 0; k < 8; k++) begin
            send_sample(8'sd127, 0, got, lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e || (k == 7 && got !== lim)) begin
                errors++; $display("FAIL overflow[%0d]: ok=%b out_data=%0d required %0d", k, ok, got, e);
            end
        end
    endtask

    task automatic test_backpressure();
        logic signed [DW-1:0] held, e;
        int n; bit bad;
        do_reset();
        write_coef(0, 8'sd64); write_coef(1, -8'sd32);
        out_ready = 1'b0; in_valid = 1'b1; in_data = -8'sd90;
        @(posedge clk);
        model_accept(-8'sd90);
        #1; in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        held = out_data; bad = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (!out_valid || held !== e) begin
            errors++; $display("FAIL backpressure_data: out_valid=%b out_data=%0d required %0d", out_valid, held, e);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL backpressure_hold: out_data=%0d in_ready=%b out_valid=%b required %0d 0 1",
                               out_data, in_ready, out_valid, held);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                               out_valid, in_ready, busy);
        end
    endtask

    task automatic test_coef_during_mac();
        logic signed [DW-1:0] got, e;
        int n; bit ok;
        int lat;
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, DW'(i * 9 - 20));
        send_sample(8'sd40, 0, got, lat, ok);
        void'(exp_q.pop_front());
        in_valid = 1'b1; in_data = -8'sd70;
        @(posedge clk);
        model_accept(-8'sd70);
        #1; in_valid = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd2; coef_data = 8'sd5;
        @(posedge clk); #1;
        coef_we = 1'b0;
        checks++;
        if (coef_err !== 1'b1) begin
            errors++; $display("FAIL coef_err_pulse: coef_err=%b required 1", coef_err);
        end
        @(posedge clk); #1;
        checks++;
        if (coef_err !== 1'b0) begin
            errors++; $display("FAIL coef_err_width: coef_err=%b required 0", coef_err);
        end
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        e = exp_q.pop_front();
        checks++;
        if (!out_valid || out_data !== e) begin
            errors++; $display("FAIL mac_write_result: out_data=%0d required %0d", out_data, e);
        end
        @(posedge clk); #1;
        send_sample(8'sd33, 0, got, lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
            errors++; $display("FAIL mac_write_coefs_kept: out_data=%0d required %0d", got, e);
        end
    endtask

    task automatic test_reset_in_mac();
        logic signed [DW-1:0] got, e;
        int lat; bit ok, seen;
        write_coef(0, 8'sd64);
        in_valid = 1'b1; in_data = 8'sd77;
        @(posedge clk);
        #1; in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_mac: busy=%b out_valid=%b in_ready=%b required 0 0 0",
                               busy, out_valid, in_ready);
        end
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_abort: out_valid_seen=%b in_ready=%b required 0 1", seen, in_ready);
        end
        write_coef(0, 8'sd64);
        send_sample(8'sd100, 0, got, lat, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e || got !== 8'sd50) begin
            errors++; $display("FAIL after_abort: out_data=%0d required %0d (50)", got, e);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [DW-1:0] got, e, d;
        int lat; bit ok;
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, DW'($urandom_range(0, 255)));
        for (int k = 0; k < 12; k++) begin
            d = DW'($urandom_range(0, 255));
            send_sample(d, $urandom_range(0, 3), got, lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got !== e || lat !== TAPS + 1) begin
                errors++; $display("FAIL back_to_back[%0d]: ok=%b out_data=%0d lat=%0d required %0d lat %0d",
                                   k, ok, got, lat, e, TAPS + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tap();
        test_impulse();
        test_overflow();
        test_backpressure();
        test_coef_during_mac();
        test_reset_in_mac();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
